// File: rtl/spatz_pkg.sv
// Shared Spatz types: memory request/response payloads and the access-size encoding.
package spatz_pkg;

  localparam int unsigned ELEN          = 32;
  localparam int unsigned ELENB         = ELEN / 8;
  localparam int unsigned NRVREG        = 32;
  localparam int unsigned MemRspIdWidth = $clog2(NRVREG);

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  // The id carries one extra MSB that the responder drops.
  typedef struct packed {
    logic [MemRspIdWidth:0] id;
    logic [31:0]            addr;
    logic [1:0]             mode;
    mem_size_e              size;
    logic                   we;
    logic [ELENB-1:0]       strb;
    logic [ELEN-1:0]        wdata;
    logic                   last;
    logic                   spec;
  } spatz_mem_req_t;

  typedef struct packed {
    logic [MemRspIdWidth-1:0] id;
    logic [ELEN-1:0]          rdata;
    logic                     err;
  } spatz_mem_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic FIFO with optional fall-through; synchronous active-low reset clears pointers and storage.
module fifo_v3 #(
  parameter bit           FALL_THROUGH = 1'b0,
  parameter int unsigned  DATA_WIDTH   = 32,
  parameter int unsigned  DEPTH        = 8,
  parameter type          dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastIdx = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH-1:0] PtrOne  = ADDR_DEPTH'(1);
  localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH + 1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0]   CntOne  = (ADDR_DEPTH + 1)'(1);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  dtype                  mem_q [DEPTH];
  logic                  bypass, do_push, do_pop;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;
  assign full_o  = (cnt_q == FullCnt);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

  // In fall-through mode a push and pop on an empty FIFO pass straight through.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && !empty_o && !bypass;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrOne;
      end
      if (do_pop) rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntOne;
        2'b01:   cnt_q <= cnt_q - CntOne;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/spatz_mem_responder.sv
// Memory-port responder: serves Spatz requests from a 1-cycle-latency SRAM and returns
// one response per request, in order, through a credit-managed response FIFO.
module spatz_mem_responder
  import spatz_pkg::*;
#(
  parameter logic [31:0]  BaseAddr = 32'h0000_0000,
  parameter int unsigned  MemBytes = 4096,
  parameter int unsigned  RspDepth = 4,
  localparam int unsigned SramAw   = $clog2(MemBytes / ELENB)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  spatz_mem_req_t    req_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output spatz_mem_resp_t   rsp_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [ELEN-1:0]   sram_wdata_o,
  output logic [ELENB-1:0]  sram_be_o,
  input  logic [ELEN-1:0]   sram_rdata_i
);

  localparam int unsigned OffW    = $clog2(ELENB);
  localparam int unsigned CntW    = $clog2(RspDepth + 1);
  localparam int unsigned FifoAw  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [CntW-1:0] CreditMax = CntW'(RspDepth);
  localparam logic [CntW-1:0] CreditOne = CntW'(1);

  typedef struct packed {
    logic                     valid;
    logic [MemRspIdWidth-1:0] id;
    logic                     err;
    logic                     we;
  } inflight_t;

  logic [CntW-1:0]   credits_q;
  inflight_t         inflight_q;
  spatz_mem_resp_t   fifo_in;
  logic [31:0]       offset;
  logic              accept, pop, in_range, misaligned, req_err;
  logic              fifo_full, fifo_empty;
  logic [FifoAw-1:0] fifo_usage_unused;
  logic              unused_req_bits;

  assign unused_req_bits = ^{req_i.mode, req_i.last, req_i.spec, req_i.id[MemRspIdWidth], offset};

  // Handshakes: a request transfers on a cycle with req_valid_i && req_ready_o, a response
  // on a cycle with rsp_valid_o && rsp_ready_i. req_ready_o depends only on registered credits.
  assign req_ready_o = (credits_q != '0);
  assign accept      = rst_ni && req_valid_i && req_ready_o;
  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;

  assign offset   = req_i.addr - BaseAddr;
  assign in_range = (req_i.addr >= BaseAddr) && (offset < MemBytes);

  always_comb begin
    misaligned = 1'b0;
    case (req_i.size)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = req_i.addr[0];
      WORD:    misaligned = |req_i.addr[1:0];
      DOUBLE:  misaligned = (ELEN == 32) ? 1'b1 : |req_i.addr[2:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign req_err = !in_range || misaligned;

  assign sram_req_o   = accept && !req_err;
  assign sram_we_o    = sram_req_o && req_i.we;
  assign sram_addr_o  = sram_req_o ? offset[OffW +: SramAw] : '0;
  assign sram_wdata_o = sram_req_o ? req_i.wdata : '0;
  assign sram_be_o    = sram_req_o ? req_i.strb : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= '{valid: accept, id: req_i.id[MemRspIdWidth-1:0], err: req_err, we: req_i.we};
    end
  end

  // Read data is only meaningful for a successful read; everything else answers with zero.
  always_comb begin
    fifo_in       = '0;
    fifo_in.id    = inflight_q.id;
    fifo_in.err   = inflight_q.err;
    fifo_in.rdata = (inflight_q.valid && !inflight_q.err && !inflight_q.we) ? sram_rdata_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      credits_q <= CreditMax;
    end else begin
      case ({accept, pop})
        2'b10:   credits_q <= credits_q - CreditOne;
        2'b01:   credits_q <= credits_q + CreditOne;
        default: credits_q <= credits_q;
      endcase
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (RspDepth),
    .dtype        (spatz_mem_resp_t)
  ) i_rsp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_usage_unused),
    .data_i     (fifo_in),
    .push_i     (inflight_q.valid),
    .data_o     (rsp_o),
    .pop_i      (pop)
  );

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q.valid |-> !fifo_full);
  a_strobe_no_err: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_req_o |-> !req_err);
  a_strobe_on_accept: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_req_o |-> accept);
  a_credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (accept && !pop) |-> (credits_q != '0));
  a_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop && !accept) |-> (credits_q != CreditMax));

endmodule

// File: tb/tb_spatz_mem_responder.sv
// Bench for spatz_mem_responder: SRAM environment, scoreboard with a memory-level model, directed tests.
module tb_spatz_mem_responder;
  import spatz_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned MEMB  = 4096;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WORDS = MEMB / ELENB;
  localparam int unsigned AW    = $clog2(WORDS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  spatz_mem_req_t   req = '0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  spatz_mem_resp_t  rsp;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             sram_req, sram_we;
  logic [AW-1:0]    sram_addr;
  logic [ELEN-1:0]  sram_wdata;
  logic [ELENB-1:0] sram_be;
  logic [ELEN-1:0]  sram_rdata = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  spatz_mem_responder #(.BaseAddr(BASE), .MemBytes(MEMB), .RspDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rsp_o(rsp), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- SRAM environment ----------------
  logic [ELEN-1:0] sram_mem [WORDS];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < int'(ELENB); b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- scoreboard / model ----------------
  spatz_mem_resp_t exp_q[$];
  int              exp_at_q[$];
  spatz_mem_resp_t got_q[$];
  int              got_cyc_q[$];
  logic [ELEN-1:0] ref_mem [WORDS];
  int              outstanding = 0;
  int              ready_low_cnt = 0;

  function automatic bit is_err(input spatz_mem_req_t r);
    longint a  = longint'(r.addr);
    longint lo = longint'(BASE);
    if (a < lo || a >= lo + longint'(MEMB)) return 1'b1;
    if (r.size == DOUBLE) return 1'b1;
    return (a % (longint'(1) << r.size)) != 0;
  endfunction

  always @(negedge clk) begin
    spatz_mem_resp_t e;
    bit exp_valid, acc, err, strobe;
    int widx;
    if (!rst_n) begin
      check("sram_req_in_reset", {63'd0, sram_req}, 64'd0);
      exp_q.delete();
      exp_at_q.delete();
      outstanding = 0;
    end else begin
      check("req_ready", {63'd0, req_ready}, {63'd0, outstanding < int'(DEPTH)});
      if (!req_ready) ready_low_cnt++;
      exp_valid = (exp_q.size() > 0) && (exp_at_q[0] <= cyc);
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
      if (rsp_valid && exp_valid) check("rsp", 64'(rsp), 64'(exp_q[0]));

      acc    = req_valid && req_ready;
      err    = is_err(req);
      strobe = acc && !err;
      widx   = int'((req.addr - BASE) / ELENB);
      check("sram_req", {63'd0, sram_req}, {63'd0, strobe});
      if (strobe)
        check("sram_fields", 64'({sram_we, sram_addr, sram_wdata, sram_be}),
              64'({req.we, AW'(widx), req.wdata, req.strb}));
      else
        check("sram_idle", 64'({sram_we, sram_addr, sram_wdata, sram_be}), 64'd0);

      if (acc) begin
        e       = '0;
        e.id    = req.id[MemRspIdWidth-1:0];
        e.err   = err;
        if (!err) begin
          if (req.we) begin
            for (int b = 0; b < int'(ELENB); b++)
              if (req.strb[b]) ref_mem[widx][8*b +: 8] = req.wdata[8*b +: 8];
          end else begin
            e.rdata = ref_mem[widx];
          end
        end
        exp_q.push_back(e);
        exp_at_q.push_back(cyc + 2);
        outstanding++;
      end

      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_rsp: got response %0h with nothing outstanding (cycle %0d)", rsp, cyc);
        end else begin
          void'(exp_q.pop_front());
          void'(exp_at_q.pop_front());
          outstanding--;
        end
        got_q.push_back(rsp);
        got_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [31:0] addr, input mem_size_e size,
                      input logic [ELENB-1:0] strb, input logic [ELEN-1:0] wdata,
                      input logic [MemRspIdWidth:0] id, output int acc_cyc, output logic strobe);
    req       = '0;
    req.we    = we;
    req.addr  = addr;
    req.size  = size;
    req.strb  = strb;
    req.wdata = wdata;
    req.id    = id;
    req.mode  = 2'b11;
    req_valid = 1'b1;
    acc_cyc   = -1;
    strobe    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc;
        strobe  = sram_req;
        break;
      end
    end
    if (acc_cyc < 0) fail_timeout("send");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (i == 100) fail_timeout("drain");
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int a0, a1, base, nacc, rel, resume, first, low0;
    logic s0, s1, acc_now;

    for (int i = 0; i < int'(WORDS); i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp", 64'(rsp), 64'd0);
    @(posedge clk); #1;

    // write then read back
    base = got_q.size();
    send(1'b1, BASE + 32'd8, WORD, 4'hF, 32'hDEAD_BEEF, 6'd1, a0, s0);
    send(1'b0, BASE + 32'd8, WORD, 4'hF, 32'h0, 6'd5, a1, s1);
    drain();
    check("wr_rd_count", 64'(got_q.size() - base), 64'd2);
    check("wr_rsp", 64'(got_q[base]), 64'({5'd1, 32'h0, 1'b0}));
    check("rd_rsp", 64'(got_q[base+1]), 64'({5'd5, 32'hDEAD_BEEF, 1'b0}));
    check("rd_latency", 64'(got_cyc_q[base+1] - a1), 64'd2);

    // byte strobe
    base = got_q.size();
    send(1'b1, 32'h0, WORD, 4'b0010, 32'h1122_3344, 6'd2, a0, s0);
    send(1'b0, 32'h0, WORD, 4'hF, 32'h0, 6'd3, a1, s1);
    drain();
    check("strb_rdata", 64'(got_q[base+1].rdata), 64'h0000_3300);

    // error cases and the last valid word
    base = got_q.size();
    send(1'b0, BASE + MEMB, WORD, 4'hF, 32'h0, 6'd6, a0, s0);
    check("oor_no_strobe", {63'd0, s0}, 64'd0);
    send(1'b0, BASE + 32'd2, WORD, 4'hF, 32'h0, 6'd7, a0, s0);
    check("misaligned_no_strobe", {63'd0, s0}, 64'd0);
    send(1'b0, BASE + 32'd16, DOUBLE, 4'hF, 32'h0, 6'd8, a0, s0);
    check("double_no_strobe", {63'd0, s0}, 64'd0);
    send(1'b0, BASE + 32'd10, HALF, 4'hF, 32'h0, 6'd41, a0, s0);
    check("half_strobe", {63'd0, s0}, 64'd1);
    send(1'b1, BASE + MEMB - 32'd4, WORD, 4'hF, 32'hCAFE_F00D, 6'd12, a0, s0);
    check("last_word_strobe", {63'd0, s0}, 64'd1);
    drain();
    check("oor_rsp", 64'(got_q[base]), 64'({5'd6, 32'h0, 1'b1}));
    check("misaligned_rsp", 64'(got_q[base+1]), 64'({5'd7, 32'h0, 1'b1}));
    check("double_rsp_err", {63'd0, got_q[base+2].err}, 64'd1);
    check("half_rsp", 64'(got_q[base+3]), 64'({5'd9, 32'hDEAD_BEEF, 1'b0}));

    // back-pressure
    base = got_q.size();
    rsp_ready = 1'b0;
    req = '0;
    req.size = WORD;
    req.addr = BASE;
    req_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc_now = req_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        nacc++;
        req.id   = 6'(nacc);
        req.addr = BASE + 32'(4 * nacc);
      end
    end
    check("bp_accepted", 64'(nacc), 64'(DEPTH));
    check("bp_ready_low", {63'd0, req_ready}, 64'd0);
    rsp_ready = 1'b1;
    rel = cyc;
    resume = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin
        resume = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    check("bp_resume", 64'(resume - rel), 64'd1);
    check("bp_first_pop", 64'(got_cyc_q[base] - rel), 64'd0);
    for (int i = 0; i < 5; i++) check("bp_order", 64'(got_q[base+i].id), 64'(i));

    // throughput
    base = got_q.size();
    low0 = ready_low_cnt;
    nacc = 0;
    first = -1;
    for (int i = 0; i < 200 && nacc < 64; i++) begin
      req       = '0;
      req.size  = WORD;
      req.id    = 6'(nacc);
      req.addr  = BASE + 32'(4 * (nacc % 16));
      req_valid = 1'b1;
      @(negedge clk);
      if (req_ready) begin
        if (first < 0) first = cyc;
        nacc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();
    check("tp_accepted", 64'(nacc), 64'd64);
    check("tp_rsps", 64'(got_q.size() - base), 64'd64);
    check("tp_span", 64'(got_cyc_q[got_cyc_q.size()-1] - first + 1), 64'd66);
    check("tp_ready_low", 64'(ready_low_cnt - low0), 64'd0);

    // reset with responses outstanding
    rsp_ready = 1'b0;
    send(1'b0, BASE + 32'd8, WORD, 4'hF, 32'h0, 6'd10, a0, s0);
    send(1'b0, BASE + 32'd4, WORD, 4'hF, 32'h0, 6'd11, a0, s0);
    send(1'b0, BASE + 32'd0, WORD, 4'hF, 32'h0, 6'd12, a0, s0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    base = got_q.size();
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_stale", 64'(got_q.size() - base), 64'd0);

    // SRAM contents survive reset
    base = got_q.size();
    send(1'b0, BASE + 32'd8, WORD, 4'hF, 32'h0, 6'd33, a0, s0);
    drain();
    check("post_rst_rd", 64'(got_q[base]), 64'({5'd1, 32'hDEAD_BEEF, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spatz_mem_responder.md
# spatz_mem_responder

Responder end of the Spatz memory port: accepts `spatz_mem_req_t` requests from the VLSU side, performs them on a single-port SRAM with fixed one-cycle read latency, and returns one `spatz_mem_resp_t` per request in order. Used as the TCDM-side endpoint in standalone Spatz testbenches and as the local scratchpad adapter in small configurations. Buffers responses in a credit-managed FIFO, so back-pressure on the response channel never drops data.

## Interface
Parameters:
- `BaseAddr`, default `32'h0000_0000`: first byte address served.
- `MemBytes`, default `4096`: bytes served; power of two, multiple of `ELENB`.
- `RspDepth`, default `4`: response FIFO depth; at least 3 for full throughput.

Ports:
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, synchronous, active-low.
- `req_i` in, `spatz_mem_req_t`: request payload.
- `req_valid_i` in, 1: request valid.
- `req_ready_o` out, 1: request accepted when high together with `req_valid_i`.
- `rsp_o` out, `spatz_mem_resp_t`: response payload.
- `rsp_valid_o` out, 1: response valid.
- `rsp_ready_i` in, 1: response consumed.
- `sram_req_o` out, 1: SRAM access strobe.
- `sram_we_o` out, 1: SRAM write enable.
- `sram_addr_o` out, `$clog2(MemBytes/ELENB)`: SRAM word index.
- `sram_wdata_o` out, `ELEN`: write data.
- `sram_be_o` out, `ELENB`: byte enables, taken from `req_i.strb`.
- `sram_rdata_i` in, `ELEN`: read data, valid exactly one cycle after a read strobe.

## Operation
- Credits: `credits = RspDepth - (FIFO occupancy + in-flight)`. `req_ready_o = (credits != 0)` from registered state only. There is no combinational path from `rsp_ready_i` or `req_valid_i` to `req_ready_o`.
- On accept (cycle t), the request is checked for errors. An error is either of:
  - the address is outside `[BaseAddr, BaseAddr+MemBytes)`;
  - the address is misaligned for `size`: 0 = byte, 1 = half, 2 = word, 3 = double. Size 3 is an error when `ELEN==32`.
- No error: `sram_req_o=1` in cycle t. `sram_addr_o = (addr-BaseAddr)>>$clog2(ELENB)`. `sram_we_o=req_i.we`, `sram_wdata_o=req_i.wdata`, `sram_be_o=req_i.strb`.
- Error: no SRAM strobe. The response carries `err=1` and `rdata=0`.
- In-flight register (1 entry) holds `{id, err, we}` for cycle t+1. At t+1 it pushes `{id=req.id[$clog2(NRVREG)-1:0], rdata, err}` into the FIFO.
  - `rdata` is `sram_rdata_i` for a successful read, otherwise 0.
  - Writes also respond, with `rdata=0`.
- `rdata` is the full aligned SRAM word. Sub-word extraction is the requester's job.
- `mode`, `last` and `spec` are ignored. The MSB of `req.id` is dropped in the response.
- Responses leave strictly in acceptance order. Pop happens when `rsp_valid_o && rsp_ready_i`.

## Timing
- Reset (`rst_ni==0` at a clock edge):
  - FIFO and in-flight register are cleared and credits are set to `RspDepth`.
  - `req_ready_o=1`, `rsp_valid_o=0`, `rsp_o='0`.
  - `sram_req_o`, `sram_we_o`, `sram_addr_o`, `sram_wdata_o` and `sram_be_o` are 0 during reset and whenever no access is issued.
- Reset mid-operation discards all outstanding responses. An SRAM write strobed in the same cycle as reset still completes.
- Latency: accept at t, then `rsp_valid_o=1` at t+2 at the earliest (FIFO output is registered).
- Throughput: one request per cycle while `rsp_ready_i` stays high and `RspDepth>=3`.
- Simultaneous accept and pop in one cycle: credits stay unchanged.
- Full (credits==0): `req_ready_o=0` from the next cycle on. It returns high one cycle after the pop that frees a credit.
- Empty: `rsp_valid_o=0` and `rsp_o` holds its last value (don't care).
- `rsp_o` and `rsp_valid_o` stay stable while `rsp_valid_o && !rsp_ready_i`.
- Credit counter width is `$clog2(RspDepth+1)`. It never wraps; overflow and underflow are assertion failures.

## Structure
- Request and response structs come from the shared `spatz_pkg`. Add to `spatz_pkg`:
  - a `mem_size_e` enum (`BYTE`, `HALF`, `WORD`, `DOUBLE`) for the `size` field;
  - a `MemRspIdWidth = $clog2(NRVREG)` constant.
- One sub-module: `fifo_v3` from common_cells, with `FALL_THROUGH=0`, `DEPTH=RspDepth`, and `spatz_mem_resp_t` as the data type.
- Credit counter, error check and in-flight register live in this module.
- SVA: no FIFO push when full; `sram_req_o` implies no error; at most one SRAM strobe per accept.

## Test plan
- Write then read: write `wdata=32'hDEAD_BEEF`, `strb=4'hF` to `BaseAddr+8`, then read the same address with `id=5`. Two responses in order; the read returns `rdata=32'hDEAD_BEEF`, `id=5`, `err=0` at t+2.
- Byte strobe: write `32'h1122_3344` with `strb=4'b0010` over `32'h0`. A subsequent read returns `32'h0000_3300`.
- Errors:
  - read at `BaseAddr+MemBytes`: `err=1`, `rdata=0`, no `sram_req_o` pulse;
  - word read at `BaseAddr+2`: `err=1`, no SRAM strobe.
- Back-pressure: hold `rsp_ready_i=0` with `req_valid_i` stuck high. Exactly `RspDepth`=4 requests are accepted and `req_ready_o` drops. Releasing `rsp_ready_i` drains ids 0..3 in order, and acceptance resumes one cycle after the first pop.
- Throughput: 64 back-to-back reads with `rsp_ready_i=1` complete in 66 cycles, with `req_ready_o` never low.
- Reset mid-stream: assert `rst_ni=0` with 3 responses outstanding. The next cycle shows `rsp_valid_o=0` and `req_ready_o=1`, and no stale response ever appears.
